ccd_fifo_packer: RTL

CCD_FIFO_PACKER -- requirements
Module: ccd_fifo_packer

---
 rtl/ccd_fifo_packer.sv | 118 +++++++++++
 1 files changed

// File: rtl/ccd_fifo_packer.sv
// CCD pixel packer: tags each accepted pixel with its X/Y position,
// reduces RGB to 5:6:5 and emits one FIFO write per accepted pixel.
module ccd_fifo_packer #(
  parameter int          FRAME_WIDTH  = 640,
  parameter int          FRAME_HEIGHT = 480,
  parameter logic [9:0]  HIGH_WATER   = 10'd1000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic        iFrameValid,
  input  logic        iLineValid,
  input  logic        iDVAL,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  input  logic        iFIFO_WriteFull,
  input  logic [9:0]  iFIFO_WriteUsedw,
  output logic        oFIFO_WriteRequest,
  output logic [35:0] oFIFO_D,
  output logic [15:0] oFrameCount,
  output logic [15:0] oDropCount,
  output logic        oBusy
);

  localparam logic [9:0] X_MAX = 10'(FRAME_WIDTH);
  localparam logic [9:0] Y_MAX = 10'(FRAME_HEIGHT);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t     state, stateNext;
  logic       frameValidD, lineValidD;
  logic [9:0] xPos, yPos;
  logic       lineHadPixel;

  logic       sof, eof, sol, eol;
  logic       pixValid, inWindow, fifoRoom, accept, drop;
  logic [9:0] xCur;

  assign sof = iFrameValid & ~frameValidD;
  assign eof = ~iFrameValid & frameValidD;
  assign sol = iLineValid & ~lineValidD;
  assign eol = ~iLineValid & lineValidD;

  // A pixel arriving in the same cycle as line start belongs at X=0,
  // so the column is taken as already cleared in that cycle.
  assign xCur     = sol ? '0 : xPos;
  assign pixValid = (state == ACTIVE) && iDVAL && iLineValid;
  assign inWindow = (xCur < X_MAX) && (yPos < Y_MAX);
  assign fifoRoom = !iFIFO_WriteFull && (iFIFO_WriteUsedw < HIGH_WATER);
  assign accept   = pixValid && inWindow && fifoRoom;
  assign drop     = pixValid && inWindow && !fifoRoom;

  assign oBusy = (state == ACTIVE);

  // State register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= stateNext;
  end

  // Capture sequencing: enable is honoured only between frames.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (iEnable) stateNext = WAIT_SOF;
      WAIT_SOF: begin
        if (!iEnable)  stateNext = IDLE;
        else if (sof)  stateNext = ACTIVE;
      end
      ACTIVE:   if (eof) stateNext = WAIT_SOF;
      default:  stateNext = IDLE;
    endcase
  end

  // Edge-detect history, position counters, FIFO write and statistics.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      frameValidD        <= 1'b0;
      lineValidD         <= 1'b0;
      xPos               <= '0;
      yPos               <= '0;
      lineHadPixel       <= 1'b0;
      oFIFO_WriteRequest <= 1'b0;
      oFIFO_D            <= '0;
      oFrameCount        <= '0;
      oDropCount         <= '0;
    end else begin
      frameValidD        <= iFrameValid;
      lineValidD         <= iLineValid;
      oFIFO_WriteRequest <= accept;
      if (accept)
        oFIFO_D <= {xCur, yPos, iRed[9:5], iGreen[9:4], iBlue[9:5]};

      if (state == WAIT_SOF && sof && iEnable) begin
        xPos         <= '0;
        yPos         <= '0;
        lineHadPixel <= 1'b0;
        oDropCount   <= '0;
      end else if (state == ACTIVE) begin
        if (pixValid) begin
          xPos         <= (xCur < X_MAX) ? xCur + 10'd1 : xCur;
          lineHadPixel <= 1'b1;
        end else if (sol) begin
          xPos         <= '0;
          lineHadPixel <= 1'b0;
        end
        if (eol) begin
          lineHadPixel <= 1'b0;
          if (lineHadPixel && (yPos < Y_MAX)) yPos <= yPos + 10'd1;
        end
        if (drop && (oDropCount != 16'hFFFF)) oDropCount <= oDropCount + 16'd1;
        if (eof) oFrameCount <= oFrameCount + 16'd1;
      end
    end
  end

endmodule
